// File: rtl/sr_ctrl_stack.sv
// sr_ctrl_stack: status register with masked flag/bus writes and an interrupt shadow stack
module sr_ctrl_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] FLAG_MASK = 16'h0107,
  parameter int GIE_BIT = 3,
  parameter logic [WIDTH-1:0] LPM_MASK = 16'h00F0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           flag_in,
  input  logic                       flag_we,
  input  logic [WIDTH-1:0]           bus_in,
  input  logic                       bus_we,
  input  logic                       irq_enter,
  input  logic                       reti,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           sr_out,
  output logic                       gie,
  output logic [$clog2(DEPTH+1)-1:0] stack_depth,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       stack_err
);
  localparam int DW = $clog2(DEPTH+1);
  localparam logic [WIDTH-1:0] CLR_MASK = LPM_MASK | (WIDTH'(1) << GIE_BIT);
  logic [WIDTH-1:0] stack [DEPTH];
  logic [WIDTH-1:0] top;
  logic             push, pop, err_set;
  assign stack_full  = stack_depth == DW'(DEPTH);
  assign stack_empty = stack_depth == '0;
  assign gie         = sr_out[GIE_BIT];
  assign push        = irq_enter && !stack_full;
  assign pop         = reti && !irq_enter && !stack_empty;
  assign err_set     = (irq_enter && stack_full) || (reti && !irq_enter && stack_empty);
  // Entry selection by compare avoids index-width mismatches between depth and the array
  always_comb begin
    top = stack[0];
    for (int i = 0; i < DEPTH; i++)
      if (stack_depth == DW'(i + 1)) top = stack[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_out      <= '0;
      stack_depth <= '0;
      stack_err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else begin
      stack_err <= err_set || (stack_err && !err_clr);
      for (int i = 0; i < DEPTH; i++)
        if (push && stack_depth == DW'(i)) stack[i] <= sr_out;
      if (irq_enter) begin
        sr_out <= sr_out & ~CLR_MASK;
        if (push) stack_depth <= stack_depth + DW'(1);
      end else if (reti) begin
        if (pop) begin
          sr_out      <= top;
          stack_depth <= stack_depth - DW'(1);
        end
      end else if (bus_we) begin
        sr_out <= bus_in;
      end else if (flag_we) begin
        sr_out <= (sr_out & ~FLAG_MASK) | (flag_in & FLAG_MASK);
      end
    end
  end
endmodule
